// File: rtl/key_debounce.sv
// Two-channel key conditioner: 2-flop synchroniser plus debounce/long-press FSM per key.
// Each key yields a press pulse, a debounced level and a long-press pulse.

module key_debounce_ch #(
    parameter int unsigned DEB_CNT  = 10000,
    parameter int unsigned LONG_CYC = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o,
    output logic level_o,
    output logic long_o
);

    localparam int unsigned CMAX = (DEB_CNT > LONG_CYC) ? DEB_CNT : LONG_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CNT - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYC);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    sync_q;
    logic          press_q;
    logic          level_q;
    logic          long_q;
    logic          s;

    assign s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], key_i};
        end
    end

    // Transitions fire on the edge where the DEB_CNT-th stable sample is seen,
    // so the registered pulse/level appear DEB_CNT cycles after s changes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            level_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            press_q <= 1'b0;
            long_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        if (DEB_CNT <= 1) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                            press_q <= 1'b1;
                            level_q <= 1'b1;
                        end else begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        if (DEB_CNT <= 1) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                        end else begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= ONE;
                        end
                    end else if (cnt_q != LONG_MAX) begin
                        cnt_q  <= cnt_q + ONE;
                        long_q <= (cnt_q == LONG_LAST);
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign press_o = press_q;
    assign level_o = level_q;
    assign long_o  = long_q;

endmodule

module key_debounce #(
    parameter int unsigned DEB_CNT  = 10000,
    parameter int unsigned LONG_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_rst_in,
    input  logic key_ps_in,
    output logic key_rst_p,
    output logic key_ps_p,
    output logic key_rst_lvl,
    output logic key_ps_lvl,
    output logic key_rst_long,
    output logic key_ps_long
);

    key_debounce_ch #(
        .DEB_CNT (DEB_CNT),
        .LONG_CYC(LONG_CYC)
    ) u_rst (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .key_i  (key_rst_in),
        .press_o(key_rst_p),
        .level_o(key_rst_lvl),
        .long_o (key_rst_long)
    );

    key_debounce_ch #(
        .DEB_CNT (DEB_CNT),
        .LONG_CYC(LONG_CYC)
    ) u_ps (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .key_i  (key_ps_in),
        .press_o(key_ps_p),
        .level_o(key_ps_lvl),
        .long_o (key_ps_long)
    );

endmodule
